// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests and buffers responses for decode.
// Optional FETCH_BYPASS_EN: presents a response to decode in its arrival cycle when the queue is empty.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fpc;
    logic [CW-1:0]         outstanding, drop, count;
    logic [PW-1:0]         q_rd, q_wr, t_rd, t_wr;
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic [ADDR_WIDTH-1:0] t_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] last_instr;
    logic [ADDR_WIDTH-1:0] last_pc;
    logic                  pop, q_pop, q_push, req_fire, rsp_keep, bypass, q_nonempty;
    logic [CW:0]           occ;

    always_comb begin
        q_nonempty = (count != '0);
        rsp_keep   = imem_rsp_valid && (drop == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass     = rsp_keep && !q_nonempty && !rst;
`else
        bypass     = 1'b0;
`endif
        instr_valid = q_nonempty || bypass;
        if (q_nonempty) begin
            instr    = q_data[q_rd];
            instr_pc = q_pc[q_rd];
        end else if (bypass) begin
            instr    = imem_rsp_data;
            instr_pc = t_pc[t_rd];
        end else begin
            instr    = last_instr;
            instr_pc = last_pc;
        end
        pop    = instr_valid && instr_ready;
        q_pop  = pop && q_nonempty;
        // a bypassed response that decode takes immediately never occupies a slot
        q_push = rsp_keep && !(bypass && instr_ready);
        occ    = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
        imem_req_valid = !rst && !redirect_valid && (occ < (CW+1)'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        imem_req_addr  = fpc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
            last_instr  <= '0;
            last_pc     <= '0;
        end else begin
            last_instr  <= instr;
            last_pc     <= instr_pc;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (req_fire)       t_wr <= t_wr + PW'(1);
            if (imem_rsp_valid) t_rd <= t_rd + PW'(1);
            if (redirect_valid) begin
                fpc   <= redirect_pc & ~ADDR_WIDTH'(3);
                // responses still owed after this cycle's one are all stale
                drop  <= outstanding - CW'(imem_rsp_valid);
                count <= '0;
                q_rd  <= '0;
                q_wr  <= '0;
            end else begin
                if (req_fire) fpc <= fpc + ADDR_WIDTH'(4);
                if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
                if (q_push) q_wr <= q_wr + PW'(1);
                if (q_pop)  q_rd <= q_rd + PW'(1);
                count <= count + CW'(q_push) - CW'(q_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) t_pc[t_wr] <= fpc;
        if (q_push && !redirect_valid) begin
            q_data[q_wr] <= imem_rsp_data;
            q_pc[q_wr]   <= t_pc[t_rd];
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a bench-side PC model predicts every instruction decode must see.
module tb_fetch_stage;
`ifdef FETCH_BYPASS_EN
    localparam int          L0 = 1, LR = 2, NP1 = 3;
    localparam logic [31:0] STALL_PC = 32'hC;
`else
    localparam int          L0 = 2, LR = 3, NP1 = 2;
    localparam logic [31:0] STALL_PC = 32'h8;
`endif

    logic        clk = 1'b0, rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc, redirect_pc;
    logic        instr_valid, instr_ready, redirect_valid;

    fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    exp_t  sb[$];
    pend_t pend[$];

    int          n_chk = 0, n_fail = 0, cyc = 0, npops = 0;
    int          lat_max = 1, first_valid_cyc = -1, redir_cyc = 0, first_pop_cyc = -1;
    logic        rdy_rand = 1'b0, last_pop, last_rsp, last_reqv, w_req = 1'b0, w_pop = 1'b0;
    logic [31:0] exp_fpc = 32'h0, last_pop_pc, first_req_addr, first_pop_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock cycle: drive at negedge, evaluate the model, commit at posedge
    task automatic step(input logic rv, input logic [31:0] rpc, input logic ir);
        exp_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = ir;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        last_pop  = instr_valid && instr_ready;
        last_rsp  = imem_rsp_valid;
        last_reqv = imem_req_valid;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (last_pop) begin
            npops++;
            last_pop_pc = instr_pc;
            if (w_pop) begin
                w_pop = 1'b0;
                first_pop_pc  = instr_pc;
                first_pop_cyc = cyc;
            end
            if (sb.size() == 0) check("spurious_instr", 1'b1, 1'b0);
            else begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.data);
            end
        end
        if (rv) begin
            check("req_in_redirect", imem_req_valid, 1'b0);
            sb.delete();
            exp_fpc   = {rpc[31:2], 2'b00};
            redir_cyc = cyc;
            w_req = 1'b1;
            w_pop = 1'b1;
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fpc);
            if (w_req) begin
                w_req = 1'b0;
                first_req_addr = imem_req_addr;
            end
            sb.push_back('{pc: exp_fpc, data: mem(exp_fpc)});
            pend.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(1, lat_max)});
            exp_fpc += 32'h4;
        end
        if (imem_rsp_valid) void'(pend.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // streaming from reset, k = 1
        w_req = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("first_req_addr", first_req_addr, 32'h0);
        check("first_valid_cyc", first_valid_cyc, L0);
        check("pops_phase1", npops, NP1);

        // decode stall: fetch must stop at DEPTH entries in flight or buffered
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        check("stall_req_valid", last_reqv, 1'b0);
        check("stall_inflight", sb.size(), 2);
        step(1'b0, '0, 1'b1);
        check("release_pop", last_pop, 1'b1);
        check("release_pc", last_pop_pc, STALL_PC);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // redirect coinciding with a response and a pop
`ifdef FETCH_BYPASS_EN
        step(1'b0, '0, 1'b0);
`endif
        step(1'b1, 32'h100, 1'b1);
        check("redir_pop", last_pop, 1'b1);
        check("redir_rsp", last_rsp, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        check("redir_req_addr", first_req_addr, 32'h100);
        check("redir_first_pc", first_pop_pc, 32'h100);
        check("redir_latency", first_pop_cyc - redir_cyc, LR);

        // misaligned target with responses still in flight
        lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h203, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        check("misalign_req_addr", first_req_addr, 32'h200);
        check("misalign_first_pc", first_pop_pc, 32'h200);

        // random backpressure, latency and redirects
        rdy_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) step(1'b1, $urandom_range(0, 32'hFFF), 1'($urandom_range(0, 1)));
            else step(1'b0, '0, 1'($urandom_range(0, 3) != 0));
        end
        rdy_rand = 1'b0;
        lat_max  = 1;
        p = npops;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        check("liveness", npops > p + 10, 1'b1);

        // reset mid-operation clears outputs immediately
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", imem_req_valid, 1'b0);
        check("mid_rst_instr_valid", instr_valid, 1'b0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
